// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - RV32I instruction fetch stage with IF/ID pipeline register
// Issues sequential fetches, buffers in-order responses, and squashes wrong-path words on flush.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_inst
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          run_q;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] iq_wp_q, iq_wp_d, iq_rp_q, iq_rp_d;
    logic [AW-1:0] ff_wp_q, ff_wp_d, ff_rp_q, ff_rp_d;
    logic          ifid_valid_q, ifid_valid_d;
    logic [31:0]   ifid_pc_q, ifid_pc_d;
    logic [31:0]   ifid_inst_q, ifid_inst_d;

    logic [31:0]   iq_pc   [FIFO_DEPTH];
    logic [31:0]   ff_pc   [FIFO_DEPTH];
    logic [31:0]   ff_inst [FIFO_DEPTH];

    logic          accept, rsp_fire, rsp_keep, push, pop;
    logic [CW:0]   used;

    assign rsp_fire = imem_rsp_valid && (out_q != '0);
    assign rsp_keep = rsp_fire && (drop_q == '0);
    assign push     = rsp_keep && !flush;
    assign pop      = en && !flush && (cnt_q != '0);

    // Credit counts the slot freed by a pop this cycle so a 1-cycle memory sustains one fetch per cycle.
    assign used           = {1'b0, out_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
    assign imem_req_valid = run_q && !flush && (used < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_inst  = ifid_inst_q;

    always_comb begin
        pc_d         = pc_q;
        out_d        = out_q + CW'(accept) - CW'(rsp_fire);
        drop_d       = drop_q;
        cnt_d        = cnt_q + CW'(push) - CW'(pop);
        iq_wp_d      = iq_wp_q;
        iq_rp_d      = iq_rp_q;
        ff_wp_d      = ff_wp_q;
        ff_rp_d      = ff_rp_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;

        if (accept) begin
            pc_d    = pc_q + 32'd4;
            iq_wp_d = iq_wp_q + PTR_ONE;
        end
        if (rsp_keep) begin
            iq_rp_d = iq_rp_q + PTR_ONE;
        end
        if (rsp_fire && (drop_q != '0)) begin
            drop_d = drop_q - CNT_ONE;
        end
        if (push) begin
            ff_wp_d = ff_wp_q + PTR_ONE;
        end
        if (pop) begin
            ff_rp_d      = ff_rp_q + PTR_ONE;
            ifid_valid_d = 1'b1;
            ifid_pc_d    = ff_pc[ff_rp_q];
            ifid_inst_d  = ff_inst[ff_rp_q];
        end else if (en) begin
            ifid_valid_d = 1'b0;
            ifid_inst_d  = NOP_INST;
        end

        // Every request still in flight at a redirect belongs to the wrong path.
        if (flush) begin
            pc_d         = flush_pc;
            drop_d       = out_q - CW'(rsp_fire);
            cnt_d        = '0;
            iq_wp_d      = '0;
            iq_rp_d      = '0;
            ff_wp_d      = '0;
            ff_rp_d      = '0;
            ifid_valid_d = 1'b0;
            ifid_inst_d  = NOP_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            iq_pc[iq_wp_q] <= pc_q;
        end
        if (push) begin
            ff_pc[ff_wp_q]   <= iq_pc[iq_rp_q];
            ff_inst[ff_wp_q] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            pc_q         <= RESET_PC;
            out_q        <= '0;
            drop_q       <= '0;
            cnt_q        <= '0;
            iq_wp_q      <= '0;
            iq_rp_q      <= '0;
            ff_wp_q      <= '0;
            ff_rp_q      <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0;
            ifid_inst_q  <= NOP_INST;
        end else begin
            run_q        <= 1'b1;
            pc_q         <= pc_d;
            out_q        <= out_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
            iq_wp_q      <= iq_wp_d;
            iq_rp_q      <= iq_rp_d;
            ff_wp_q      <= ff_wp_d;
            ff_rp_q      <= ff_rp_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
        end
    end

    a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (out_q != '0));
    a_flush_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        flush |-> (flush_pc[1:0] == 2'b00));

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized scoreboard bench for if_fetch_stage
module tb_if_fetch_stage;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;

    if_fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .flush_pc(flush_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
        .ifid_inst(ifid_inst)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    req_t        mq[$];
    ent_t        bq[$];
    logic [31:0] log_pc[$];
    bit          log_v[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc, last_due, low_cnt;
    int          lat_min, lat_max, ready_pct, en_pct, flush_pct;
    bit          force_flush = 1'b0;
    logic [31:0] force_pc;
    logic [31:0] next_addr, e_pc, e_inst, prev_addr, first_pc;
    bit          e_valid, prev_stuck, want_first;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[17:2]} + 32'h0101_0101;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int rdy, input int enp, input int flp);
        lat_min = lmin; lat_max = lmax; ready_pct = rdy; en_pct = enp; flush_pct = flp;
    endtask

    task automatic model_reset();
        mq.delete(); bq.delete(); log_pc.delete(); log_v.delete();
        cyc = 0; last_due = -1; next_addr = RPC;
        e_valid = 1'b0; e_pc = 32'h0; e_inst = NOP;
        prev_stuck = 1'b0; want_first = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; flush_pc = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        #1;
        check_eq("rst_req_valid", imem_req_valid, 32'h0);
        check_eq("rst_ifid_valid", ifid_valid, 32'h0);
        check_eq("rst_ifid_pc", ifid_pc, 32'h0);
        check_eq("rst_ifid_inst", ifid_inst, NOP);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step();
        int   lat;
        bit   acc;
        ent_t e;
        req_t r;
        @(negedge clk);
        en = ($urandom_range(99) < en_pct);
        if (force_flush) begin
            flush = 1'b1; flush_pc = force_pc; force_flush = 1'b0;
        end else begin
            flush = ($urandom_range(99) < flush_pct);
            flush_pc = 32'h100 + ($urandom_range(63) << 2);
        end
        imem_req_ready = ($urandom_range(99) < ready_pct);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
        end
        #1;
        if (flush) begin
            check_eq("req_blocked_by_flush", imem_req_valid, 32'h0);
        end else if (prev_stuck) begin
            check_eq("req_valid_held", imem_req_valid, 32'h1);
            check_eq("req_addr_held", imem_req_addr, prev_addr);
        end
        if (!imem_req_valid && !flush) low_cnt++;
        acc = imem_req_valid && imem_req_ready;
        if (acc) check_eq("req_addr", imem_req_addr, next_addr);

        // Decode sees only words buffered before this edge.
        if (flush) begin
            e_valid = 1'b0; e_inst = NOP;
        end else if (en) begin
            if (bq.size() > 0) begin
                e = bq.pop_front();
                e_valid = 1'b1; e_pc = e.pc; e_inst = e.inst;
            end else begin
                e_valid = 1'b0; e_inst = NOP;
            end
        end
        if (imem_rsp_valid) begin
            r = mq.pop_front();
            if (!r.stale) begin
                e.pc = r.addr; e.inst = mem_word(r.addr);
                bq.push_back(e);
            end
        end
        if (acc) begin
            lat = $urandom_range(lat_max, lat_min);
            r.addr = next_addr;
            r.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            r.stale = 1'b0;
            last_due = r.due;
            mq.push_back(r);
            next_addr = next_addr + 32'd4;
        end
        if (flush) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            bq.delete();
            next_addr = flush_pc;
            want_first = 1'b1;
            first_pc = flush_pc;
        end
        prev_stuck = imem_req_valid && !imem_req_ready && !flush;
        prev_addr = imem_req_addr;

        @(posedge clk);
        #1;
        check_eq("ifid_valid", ifid_valid, e_valid);
        check_eq("ifid_pc", ifid_pc, e_pc);
        check_eq("ifid_inst", ifid_inst, e_inst);
        if (acc) check_eq("credit_bound", (mq.size() + bq.size() <= DEPTH), 32'h1);
        if (want_first && ifid_valid) begin
            check_eq("first_pc_after_flush", ifid_pc, first_pc);
            want_first = 1'b0;
        end
        log_pc.push_back(ifid_pc);
        log_v.push_back(ifid_valid);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        #3;
        do_reset();

        set_knobs(1, 1, 100, 100, 0);
        run(5);
        for (int k = 0; k < 3; k++) begin
            check_eq("stream_valid", log_v[2 + k], 32'h1);
            check_eq("stream_pc", log_pc[2 + k], RPC + 32'(4 * k));
        end

        low_cnt = 0;
        set_knobs(1, 1, 100, 0, 0);
        run(3);
        check_eq("stall_hold_pc", ifid_pc, 32'h8);
        check_eq("stall_credit_stop", (low_cnt > 0), 32'h1);
        set_knobs(1, 1, 100, 100, 0);
        run(6);
        check_eq("resume_pc0", log_pc[8], 32'hC);
        check_eq("resume_pc1", log_pc[9], 32'h10);

        set_knobs(1, 1, 0, 100, 0);
        run(4);
        set_knobs(1, 1, 100, 100, 0);
        run(6);

        set_knobs(3, 3, 100, 100, 0);
        run(6);
        force_flush = 1'b1; force_pc = 32'h100;
        run(12);
        check_eq("flush_target_reached", want_first, 32'h0);

        set_knobs(1, 1, 100, 100, 0);
        run(6);
        check_eq("pre_flush_valid", ifid_valid, 32'h1);
        set_knobs(1, 1, 100, 0, 0);
        force_flush = 1'b1; force_pc = 32'h200;
        run(1);
        check_eq("flush_beats_stall_v", ifid_valid, 32'h0);
        check_eq("flush_beats_stall_i", ifid_inst, NOP);
        set_knobs(1, 1, 100, 100, 0);
        run(8);

        set_knobs(1, 4, 70, 75, 5);
        run(3000);

        #2;
        do_reset();
        set_knobs(1, 1, 100, 100, 0);
        run(5);
        check_eq("restart_valid", log_v[2], 32'h1);
        check_eq("restart_pc0", log_pc[2], RPC);
        check_eq("restart_pc1", log_pc[3], RPC + 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
